// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues req/ack fetches, buffers one instruction for ID.
// Optional FETCH_PERF_EN adds perf_fetched / perf_redirects counters.
module pc_fetch_unit #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PcSel,
  input  logic [31:0]      BrPC,
  input  logic             Stall,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [INS_W-1:0] imem_rdata,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [PC_W-1:0]  if_pc,
  output logic [INS_W-1:0] if_instr,
  output logic             flush
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_redirects
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, DROP} state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  req_addr_q, req_addr_d;
  logic             if_valid_q, if_valid_d;
  logic [PC_W-1:0]  if_pc_q, if_pc_d;
  logic [INS_W-1:0] if_instr_q, if_instr_d;

  logic             consume;
  logic             buf_free;
  logic             load;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  pc_inc;
  logic [31:0]      brpc_unused;

  // Only BrPC[PC_W-1:2] forms the word-aligned target.
  assign brpc_unused = BrPC;
  assign target      = {BrPC[PC_W-1:2], 2'b00};
  assign pc_inc      = pc_q + PC_W'(4);

  assign consume  = if_valid_q & if_ready & ~Stall;
  assign buf_free = ~if_valid_q | consume;
  assign flush    = PcSel;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    load       = 1'b0;
    imem_req   = 1'b0;
    imem_addr  = pc_q;
    case (state_q)
      IDLE: begin
        imem_req = buf_free & ~Stall & ~PcSel & ~reset;
        if (PcSel) begin
          pc_d = target;
        end else if (imem_req) begin
          if (imem_ack) begin
            load = 1'b1;
            pc_d = pc_inc;
          end else begin
            req_addr_d = pc_q;
            state_d    = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        imem_req  = ~reset;
        imem_addr = req_addr_q;
        if (PcSel) begin
          pc_d    = target;
          state_d = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          load    = 1'b1;
          pc_d    = pc_inc;
          state_d = IDLE;
        end
      end
      DROP: begin
        // Wait out the stale response; its data is never used.
        imem_req  = ~reset;
        imem_addr = req_addr_q;
        if (PcSel) pc_d = target;
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if (load) begin
      if_valid_d = 1'b1;
      if_pc_d    = imem_addr;
      if_instr_d = imem_rdata;
    end else if (PcSel || consume) begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      req_addr_q <= '0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_redirects_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q   <= '0;
      perf_redirects_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_q + {31'd0, consume};
      perf_redirects_q <= perf_redirects_q + {31'd0, PcSel};
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_redirects = perf_redirects_q;
`endif

endmodule
